// File: rtl/branch_sched_pkg.sv
// ---------------------------------------------------------------------------
// branch_sched_pkg
// Shared types and constants for the branch-ALU reservation station.
//   rs_entry_t : one station slot (control word, fetch-side addresses,
//                ROB tag and two source operands with ready/tag/value)
//   CTRL_*     : encodings of ctrl[7:6] ({isJAL,isJALR})
// ---------------------------------------------------------------------------
package branch_sched_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int TAG_W  = 4;

    localparam logic [1:0] CTRL_BRANCH = 2'b00;
    localparam logic [1:0] CTRL_JALR   = 2'b01;
    localparam logic [1:0] CTRL_JAL    = 2'b10;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] predictedPC;
        logic [DATA_W-1:0] targetAddress;
        logic [DATA_W-1:0] nxtPC;
        logic [TAG_W-1:0]  rob_tag;
        rs_src_t           src1;
        rs_src_t           src2;
    } rs_entry_t;

    // Classifies the op kind held in ctrl[7:6].
    function automatic logic isJal(input logic [1:0] kind);
        return kind == CTRL_JAL;
    endfunction

    function automatic logic isJalr(input logic [1:0] kind);
        return kind == CTRL_JALR;
    endfunction

    function automatic logic isCondBranch(input logic [1:0] kind);
        return kind == CTRL_BRANCH;
    endfunction

endpackage

// File: rtl/branch_issue_scheduler_age_matrix_select.sv
// ---------------------------------------------------------------------------
// age_matrix_select
// Tracks relative age of station entries and grants the oldest requester.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_alloc        : one-hot, entry being written this edge (becomes youngest)
//   i_clear        : one-hot, entry leaving the station this edge
//   i_req          : entries eligible for selection
//   o_grant        : one-hot oldest requester (all zero if none)
// ---------------------------------------------------------------------------
module age_matrix_select #(
    parameter int ENTRIES = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [ENTRIES-1:0] i_alloc,
    input  logic [ENTRIES-1:0] i_clear,
    input  logic [ENTRIES-1:0] i_req,
    output logic [ENTRIES-1:0] o_grant
);

    // r_older[i][j] = 1 means entry i is older than entry j.
    logic [ENTRIES-1:0] r_older [ENTRIES];
    logic [ENTRIES-1:0] w_blocked;

    // A new entry is younger than every other slot (column set) and older
    // than none (row cleared). A leaving entry drops its row so it never
    // blocks anyone; stale bits of invalid slots are rewritten on reuse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) r_older[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (i == j)
                        r_older[i][j] <= 1'b0;
                    else if (i_alloc[j])
                        r_older[i][j] <= 1'b1;
                    else if (i_alloc[i] || i_clear[i])
                        r_older[i][j] <= 1'b0;
                end
            end
        end
    end

    // An entry is blocked when some other requester is older than it.
    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                w_blocked[i] = w_blocked[i] | (i_req[j] & r_older[j][i] & (i != j));
            end
        end
    end

    assign o_grant = i_req & ~w_blocked;

endmodule

// File: rtl/branch_issue_scheduler.sv
// ---------------------------------------------------------------------------
// branch_issue_scheduler
// Reservation station + issue register for the branch ALU.
//   i_clk, i_reset, i_flush           : clock, async reset, pipeline redirect
//   i_alloc_* / o_alloc_ready         : renamed op from rename
//   i_cdb_*                           : result broadcast for operand wakeup
//   o_issue_* / i_issue_ready         : registered issue stage to the ALU
//   o_occupancy                       : valid station entries (not issue reg)
// ---------------------------------------------------------------------------
module branch_issue_scheduler
    import branch_sched_pkg::*;
#(
    parameter int WIDTH   = 31,
    parameter int C_WIDTH = 7,
    parameter int ENTRIES = 4,
    parameter int ROB_W   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_alloc_valid,
    output logic                         o_alloc_ready,
    input  logic [C_WIDTH:0]             i_alloc_ctrl,
    input  logic [WIDTH:0]               i_alloc_predictedPC,
    input  logic [WIDTH:0]               i_alloc_targetAddress,
    input  logic [WIDTH:0]               i_alloc_nxtPC,
    input  logic [ROB_W-1:0]             i_alloc_rob_tag,
    input  logic                         i_alloc_src1_rdy,
    input  logic                         i_alloc_src2_rdy,
    input  logic [ROB_W-1:0]             i_alloc_src1_tag,
    input  logic [ROB_W-1:0]             i_alloc_src2_tag,
    input  logic [WIDTH:0]               i_alloc_src1,
    input  logic [WIDTH:0]               i_alloc_src2,
    input  logic                         i_cdb_valid,
    input  logic [ROB_W-1:0]             i_cdb_tag,
    input  logic [WIDTH:0]               i_cdb_data,
    output logic                         o_issue_valid,
    input  logic                         i_issue_ready,
    output logic [WIDTH:0]               o_issue_src1,
    output logic [WIDTH:0]               o_issue_src2,
    output logic [C_WIDTH:0]             o_issue_ctrl,
    output logic [WIDTH:0]               o_issue_predictedPC,
    output logic [WIDTH:0]               o_issue_targetAddress,
    output logic [WIDTH:0]               o_issue_nxtPC,
    output logic [ROB_W-1:0]             o_issue_rob_tag,
    output logic [$clog2(ENTRIES):0]     o_occupancy
);

    localparam int OCC_W = $clog2(ENTRIES) + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(ENTRIES);

    rs_entry_t          r_entries [ENTRIES];
    logic [OCC_W-1:0]   r_occupancy;
    logic               r_issueValid;
    rs_entry_t          r_issue;

    logic [ENTRIES-1:0] w_allocOneHot;
    logic               w_anyFree;
    logic               w_allocFire;
    logic               w_byp1;
    logic               w_byp2;
    rs_entry_t          w_newEntry;
    logic [ENTRIES-1:0] w_req;
    logic [ENTRIES-1:0] w_grant;
    logic               w_issueLoad;
    logic               w_issueFire;
    rs_entry_t          w_sel;

    assign o_alloc_ready = (r_occupancy != FULL);
    assign w_allocFire   = i_alloc_valid & o_alloc_ready;
    assign w_issueLoad   = ~r_issueValid | i_issue_ready;
    assign w_issueFire   = w_issueLoad & (|w_grant);

    // Lowest-index free slot.
    always_comb begin
        w_allocOneHot = '0;
        w_anyFree     = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!r_entries[i].valid && !w_anyFree) begin
                w_allocOneHot[i] = 1'b1;
                w_anyFree        = 1'b1;
            end
        end
    end

    // Incoming op, with a same-cycle CDB match written straight in as ready.
    assign w_byp1 = ~i_alloc_src1_rdy & i_cdb_valid & (i_alloc_src1_tag == i_cdb_tag);
    assign w_byp2 = ~i_alloc_src2_rdy & i_cdb_valid & (i_alloc_src2_tag == i_cdb_tag);

    always_comb begin
        w_newEntry               = '0;
        w_newEntry.valid         = 1'b1;
        w_newEntry.ctrl          = i_alloc_ctrl;
        w_newEntry.predictedPC   = i_alloc_predictedPC;
        w_newEntry.targetAddress = i_alloc_targetAddress;
        w_newEntry.nxtPC         = i_alloc_nxtPC;
        w_newEntry.rob_tag       = i_alloc_rob_tag;
        w_newEntry.src1.rdy      = i_alloc_src1_rdy | w_byp1;
        w_newEntry.src1.tag      = i_alloc_src1_tag;
        w_newEntry.src1.val      = w_byp1 ? i_cdb_data : i_alloc_src1;
        w_newEntry.src2.rdy      = i_alloc_src2_rdy | w_byp2;
        w_newEntry.src2.tag      = i_alloc_src2_tag;
        w_newEntry.src2.val      = w_byp2 ? i_cdb_data : i_alloc_src2;
    end

    // Candidates use registered ready bits only, so a wakeup at edge t can
    // be selected at edge t+1 at the earliest.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < ENTRIES; i++)
            w_req[i] = r_entries[i].valid & r_entries[i].src1.rdy & r_entries[i].src2.rdy;
    end

    age_matrix_select #(
        .ENTRIES (ENTRIES)
    ) u_age (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_alloc (w_allocOneHot & {ENTRIES{w_allocFire & ~i_flush}}),
        .i_clear (w_grant & {ENTRIES{w_issueFire & ~i_flush}}),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    // One-hot grant mux over the whole entry.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (w_grant[i]) w_sel = w_sel | r_entries[i];
    end

    // Station slots: allocate, issue-clear and CDB wakeup.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) r_entries[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < ENTRIES; i++) r_entries[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_allocFire && w_allocOneHot[i]) begin
                    r_entries[i] <= w_newEntry;
                end else begin
                    if (w_issueFire && w_grant[i])
                        r_entries[i].valid <= 1'b0;
                    if (i_cdb_valid && r_entries[i].valid && !r_entries[i].src1.rdy &&
                        r_entries[i].src1.tag == i_cdb_tag) begin
                        r_entries[i].src1.rdy <= 1'b1;
                        r_entries[i].src1.val <= i_cdb_data;
                    end
                    if (i_cdb_valid && r_entries[i].valid && !r_entries[i].src2.rdy &&
                        r_entries[i].src2.tag == i_cdb_tag) begin
                        r_entries[i].src2.rdy <= 1'b1;
                        r_entries[i].src2.val <= i_cdb_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_occupancy <= '0;
        else if (i_flush)
            r_occupancy <= '0;
        else
            r_occupancy <= r_occupancy + OCC_W'(w_allocFire) - OCC_W'(w_issueFire);
    end

    // Issue register: payload only changes on a real load, so it holds
    // stable while stalled and after draining.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_issueValid <= 1'b0;
            r_issue      <= '0;
        end else if (i_flush) begin
            r_issueValid <= 1'b0;
        end else if (w_issueLoad) begin
            r_issueValid <= |w_grant;
            if (|w_grant) r_issue <= w_sel;
        end
    end

    assign o_issue_valid         = r_issueValid;
    assign o_issue_src1          = r_issue.src1.val;
    assign o_issue_src2          = r_issue.src2.val;
    assign o_issue_ctrl          = r_issue.ctrl;
    assign o_issue_predictedPC   = r_issue.predictedPC;
    assign o_issue_targetAddress = r_issue.targetAddress;
    assign o_issue_nxtPC         = r_issue.nxtPC;
    assign o_issue_rob_tag       = r_issue.rob_tag;
    assign o_occupancy           = r_occupancy;

endmodule

// File: tb/tb_branch_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_branch_issue_scheduler
// Directed-vector bench for branch_issue_scheduler with hand-computed
// expectations. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_branch_issue_scheduler;
    import branch_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        allocValid;
    logic        allocReady;
    logic [7:0]  allocCtrl;
    logic [31:0] allocPredictedPC;
    logic [31:0] allocTargetAddress;
    logic [31:0] allocNxtPC;
    logic [3:0]  allocRobTag;
    logic        allocSrc1Rdy;
    logic        allocSrc2Rdy;
    logic [3:0]  allocSrc1Tag;
    logic [3:0]  allocSrc2Tag;
    logic [31:0] allocSrc1;
    logic [31:0] allocSrc2;
    logic        cdbValid;
    logic [3:0]  cdbTag;
    logic [31:0] cdbData;
    logic        issueValid;
    logic        issueReady;
    logic [31:0] issueSrc1;
    logic [31:0] issueSrc2;
    logic [7:0]  issueCtrl;
    logic [31:0] issuePredictedPC;
    logic [31:0] issueTargetAddress;
    logic [31:0] issueNxtPC;
    logic [3:0]  issueRobTag;
    logic [2:0]  occupancy;

    int checksTotal  = 0;
    int checksPassed = 0;

    localparam logic [7:0] BEQ_CTRL = 8'b00_000_10_0;
    localparam logic [7:0] JAL_CTRL = {CTRL_JAL, 6'b000000};

    branch_issue_scheduler dut (
        .i_clk                 (clk),
        .i_reset               (reset),
        .i_flush               (flush),
        .i_alloc_valid         (allocValid),
        .o_alloc_ready         (allocReady),
        .i_alloc_ctrl          (allocCtrl),
        .i_alloc_predictedPC   (allocPredictedPC),
        .i_alloc_targetAddress (allocTargetAddress),
        .i_alloc_nxtPC         (allocNxtPC),
        .i_alloc_rob_tag       (allocRobTag),
        .i_alloc_src1_rdy      (allocSrc1Rdy),
        .i_alloc_src2_rdy      (allocSrc2Rdy),
        .i_alloc_src1_tag      (allocSrc1Tag),
        .i_alloc_src2_tag      (allocSrc2Tag),
        .i_alloc_src1          (allocSrc1),
        .i_alloc_src2          (allocSrc2),
        .i_cdb_valid           (cdbValid),
        .i_cdb_tag             (cdbTag),
        .i_cdb_data            (cdbData),
        .o_issue_valid         (issueValid),
        .i_issue_ready         (issueReady),
        .o_issue_src1          (issueSrc1),
        .o_issue_src2          (issueSrc2),
        .o_issue_ctrl          (issueCtrl),
        .o_issue_predictedPC   (issuePredictedPC),
        .o_issue_targetAddress (issueTargetAddress),
        .o_issue_nxtPC         (issueNxtPC),
        .o_issue_rob_tag       (issueRobTag),
        .o_occupancy           (occupancy)
    );

    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksTotal++;
        if (observed === expected)
            checksPassed++;
        else
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op on the allocate port; addresses derive from the ROB tag.
    task automatic applyStimulus(input logic [7:0] ctrl, input logic [3:0] rob,
                                 input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                                 input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        allocValid         = 1'b1;
        allocCtrl          = ctrl;
        allocRobTag        = rob;
        allocPredictedPC   = 32'h1000 + {26'd0, rob, 2'b00};
        allocTargetAddress = 32'h2000 + {26'd0, rob, 2'b00};
        allocNxtPC         = 32'h3000 + {26'd0, rob, 2'b00};
        allocSrc1Rdy       = r1;
        allocSrc1Tag       = t1;
        allocSrc1          = v1;
        allocSrc2Rdy       = r2;
        allocSrc2Tag       = t2;
        allocSrc2          = v2;
    endtask

    task automatic idleAlloc();
        allocValid = 1'b0;
    endtask

    task automatic setCdb(input logic v, input logic [3:0] tag, input logic [31:0] data);
        cdbValid = v;
        cdbTag   = tag;
        cdbData  = data;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        issueReady = 1'b1;
        allocValid = 1'b0; allocCtrl = '0; allocRobTag = '0;
        allocPredictedPC = '0; allocTargetAddress = '0; allocNxtPC = '0;
        allocSrc1Rdy = 1'b0; allocSrc2Rdy = 1'b0; allocSrc1Tag = '0; allocSrc2Tag = '0;
        allocSrc1 = '0; allocSrc2 = '0;
        setCdb(1'b0, 4'd0, 32'd0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_issue_valid", {31'd0, issueValid}, 32'd0);
        checkOutput("rst_occupancy", {29'd0, occupancy}, 32'd0);
        checkOutput("rst_alloc_ready", {31'd0, allocReady}, 32'd1);
        checkOutput("rst_issue_src1", issueSrc1, 32'd0);
        checkOutput("rst_issue_rob", {28'd0, issueRobTag}, 32'd0);
        reset = 1'b0;

        // Ready BEQ: allocated at edge t, in issue register after edge t+1
        applyStimulus(BEQ_CTRL, 4'd1, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
        tick();
        checkOutput("t1_occ_after_alloc", {29'd0, occupancy}, 32'd1);
        checkOutput("t1_not_yet_issued", {31'd0, issueValid}, 32'd0);
        idleAlloc();
        tick();
        checkOutput("t1_issue_valid", {31'd0, issueValid}, 32'd1);
        checkOutput("t1_src1", issueSrc1, 32'd5);
        checkOutput("t1_src2", issueSrc2, 32'd5);
        checkOutput("t1_ctrl", {24'd0, issueCtrl}, 32'h04);
        checkOutput("t1_rob", {28'd0, issueRobTag}, 32'd1);
        checkOutput("t1_pc", issuePredictedPC, 32'h1004);
        checkOutput("t1_target", issueTargetAddress, 32'h2004);
        checkOutput("t1_nxt", issueNxtPC, 32'h3004);
        checkOutput("t1_occ", {29'd0, occupancy}, 32'd0);
        tick();
        checkOutput("t1_drain", {31'd0, issueValid}, 32'd0);

        // Older A waits on tag 3; younger ready B (JAL) issues first
        applyStimulus(BEQ_CTRL, 4'd2, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd2);
        tick();
        applyStimulus(JAL_CTRL, 4'd3, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd8);
        tick();
        idleAlloc();
        setCdb(1'b1, 4'd3, 32'h10);
        tick();
        checkOutput("t2_b_first_rob", {28'd0, issueRobTag}, 32'd3);
        checkOutput("t2_b_ctrl", {24'd0, issueCtrl}, {24'd0, JAL_CTRL});
        checkOutput("t2_occ", {29'd0, occupancy}, 32'd1);
        setCdb(1'b0, 4'd0, 32'd0);
        tick();
        checkOutput("t2_a_rob", {28'd0, issueRobTag}, 32'd2);
        checkOutput("t2_a_src1", issueSrc1, 32'h10);
        checkOutput("t2_a_src2", issueSrc2, 32'd2);
        checkOutput("t2_occ_empty", {29'd0, occupancy}, 32'd0);
        tick();
        checkOutput("t2_drain", {31'd0, issueValid}, 32'd0);

        // Fill all four slots waiting on tag 7
        for (int k = 0; k < 4; k++) begin
            applyStimulus(BEQ_CTRL, 4'(4 + k), 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'(k));
            tick();
        end
        checkOutput("t3_full_ready", {31'd0, allocReady}, 32'd0);
        checkOutput("t3_full_occ", {29'd0, occupancy}, 32'd4);
        applyStimulus(BEQ_CTRL, 4'd8, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd9);
        tick();
        checkOutput("t3_fifth_rejected", {29'd0, occupancy}, 32'd4);
        idleAlloc();
        setCdb(1'b1, 4'd7, 32'h77);
        tick();
        checkOutput("t3_no_same_edge_issue", {31'd0, issueValid}, 32'd0);
        setCdb(1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t3_order_rob", {28'd0, issueRobTag}, 32'(4 + k));
            checkOutput("t3_order_src1", issueSrc1, 32'h77);
            checkOutput("t3_order_occ", {29'd0, occupancy}, 32'(3 - k));
        end
        tick();
        checkOutput("t3_drain", {31'd0, issueValid}, 32'd0);

        // Stall with two ready ops
        issueReady = 1'b0;
        applyStimulus(BEQ_CTRL, 4'd9, 1'b1, 4'd0, 32'h21, 1'b1, 4'd0, 32'h22);
        tick();
        applyStimulus(BEQ_CTRL, 4'd10, 1'b1, 4'd0, 32'h31, 1'b1, 4'd0, 32'h32);
        tick();
        checkOutput("t4_first_rob", {28'd0, issueRobTag}, 32'd9);
        checkOutput("t4_occ", {29'd0, occupancy}, 32'd1);
        idleAlloc();
        tick();
        checkOutput("t4_hold_valid", {31'd0, issueValid}, 32'd1);
        checkOutput("t4_hold_rob", {28'd0, issueRobTag}, 32'd9);
        checkOutput("t4_hold_src1", issueSrc1, 32'h21);
        tick();
        checkOutput("t4_hold_src2", issueSrc2, 32'h22);
        checkOutput("t4_hold_occ", {29'd0, occupancy}, 32'd1);
        issueReady = 1'b1;
        tick();
        checkOutput("t4_second_rob", {28'd0, issueRobTag}, 32'd10);
        checkOutput("t4_second_src1", issueSrc1, 32'h31);
        checkOutput("t4_second_occ", {29'd0, occupancy}, 32'd0);
        tick();
        checkOutput("t4_drain", {31'd0, issueValid}, 32'd0);

        // Allocate-time CDB bypass on both sources
        applyStimulus(BEQ_CTRL, 4'd11, 1'b0, 4'd2, 32'd0, 1'b0, 4'd2, 32'd0);
        setCdb(1'b1, 4'd2, 32'hABCD);
        tick();
        checkOutput("t5_occ", {29'd0, occupancy}, 32'd1);
        idleAlloc();
        setCdb(1'b0, 4'd0, 32'd0);
        tick();
        checkOutput("t5_valid", {31'd0, issueValid}, 32'd1);
        checkOutput("t5_rob", {28'd0, issueRobTag}, 32'd11);
        checkOutput("t5_src1", issueSrc1, 32'hABCD);
        checkOutput("t5_src2", issueSrc2, 32'hABCD);
        tick();

        // Flush with three station entries plus a stalled issue register
        issueReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(BEQ_CTRL, 4'(12 + k), 1'b1, 4'd0, 32'(16 + k), 1'b1, 4'd0, 32'd1);
            tick();
        end
        checkOutput("t6_pre_occ", {29'd0, occupancy}, 32'd3);
        checkOutput("t6_pre_rob", {28'd0, issueRobTag}, 32'd12);
        applyStimulus(BEQ_CTRL, 4'd0, 1'b1, 4'd0, 32'd99, 1'b1, 4'd0, 32'd99);
        issueReady = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idleAlloc();
        checkOutput("t6_issue_valid", {31'd0, issueValid}, 32'd0);
        checkOutput("t6_occ", {29'd0, occupancy}, 32'd0);
        checkOutput("t6_alloc_ready", {31'd0, allocReady}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("t6_stays_empty", {31'd0, issueValid}, 32'd0);
        end

        // Asynchronous reset in the middle of a cycle
        applyStimulus(BEQ_CTRL, 4'd3, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd0);
        tick();
        checkOutput("t7_pre_occ", {29'd0, occupancy}, 32'd1);
        idleAlloc();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t7_async_occ", {29'd0, occupancy}, 32'd0);
        reset = 1'b0;
        applyStimulus(BEQ_CTRL, 4'd6, 1'b1, 4'd0, 32'h66, 1'b1, 4'd0, 32'h67);
        tick();
        checkOutput("t7_first_alloc", {29'd0, occupancy}, 32'd1);
        idleAlloc();
        tick();
        checkOutput("t7_issue_rob", {28'd0, issueRobTag}, 32'd6);
        checkOutput("t7_issue_src2", issueSrc2, 32'h67);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/branch_issue_scheduler.md
Name: branch_issue_scheduler

Overview:
- Reservation station and issue scheduler for the branch ALU.
- Accepts renamed branch/JAL/JALR ops, captures missing operands from the CDB, and selects the oldest ready op each cycle into a registered issue stage feeding the branch ALU.
- Flushed wholesale on pipeline redirect.

Parameters:
- WIDTH, 31, MSB index of data/address fields (32-bit).
- C_WIDTH, 7, MSB index of branch control word {isJAL,isJALR,funct3,state[1:0],redirect}.
- ENTRIES, 4, station depth (power of two, >=2).
- ROB_W, 4, ROB tag width in bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline redirect; kill every entry and the issue register
- alloc_valid  in  1  rename presents an op
- alloc_ready  out  1  station can accept (count < ENTRIES)
- alloc_ctrl  in  C_WIDTH+1  branch control word
- alloc_predictedPC, alloc_targetAddress, alloc_nxtPC  in  WIDTH+1 each  fetch-side addresses
- alloc_rob_tag  in  ROB_W  destination ROB tag
- alloc_src1_rdy, alloc_src2_rdy  in  1 each  operand already valid
- alloc_src1_tag, alloc_src2_tag  in  ROB_W each  producer tag when not ready
- alloc_src1, alloc_src2  in  WIDTH+1 each  operand value when ready
- cdb_valid  in  1  common data bus broadcast
- cdb_tag  in  ROB_W  broadcast tag
- cdb_data  in  WIDTH+1  broadcast value
- issue_valid  out  1  issue register holds an op
- issue_ready  in  1  branch ALU stage accepts this cycle
- issue_src1, issue_src2  out  WIDTH+1 each  operands
- issue_ctrl  out  C_WIDTH+1  control word
- issue_predictedPC, issue_targetAddress, issue_nxtPC  out  WIDTH+1 each  addresses
- issue_rob_tag  out  ROB_W  ROB tag
- occupancy  out  $clog2(ENTRIES)+1  valid entries in the station (excludes the issue register)

Behaviour:
- Reset:
  - All entry valid bits, issue_valid and occupancy are 0.
  - The age matrix is cleared.
  - Issue data outputs are 0.
- Allocate:
  - Handshake fires on alloc_valid & alloc_ready.
  - The op is written into the lowest-index free entry at the edge.
  - The new entry becomes youngest in age order.
- alloc_ready = (occupancy != ENTRIES); computed from registered state only. A same-cycle free does not raise it.
- Wakeup:
  - On cdb_valid, every valid entry with a non-ready source whose tag equals cdb_tag latches cdb_data and sets that source ready.
  - Applies independently to src1 and src2; both may match.
- Alloc bypass: if an allocating op's non-ready source tag equals cdb_tag while cdb_valid, the op is written ready with cdb_data.
- Select:
  - Candidate = valid entry with both sources ready (registered ready bits; no same-cycle wakeup-to-select).
  - The oldest candidate per the age matrix wins.
- Issue register advance:
  - Loads when (!issue_valid | issue_ready).
  - On load, the winner's valid bit is cleared and issue_valid = 1.
  - With no candidate, issue_valid drops to 0 if issue_ready was asserted.
  - While issue_valid & !issue_ready, all issue_* outputs hold stable.
- Latency:
  - Op allocated ready at edge t is in the issue register after edge t+1.
  - Op woken by CDB at edge t issues at edge t+1 at the earliest.
- Throughput: one issue per cycle.
- Flush:
  - Highest priority.
  - At the edge, all entries and issue_valid are cleared and occupancy becomes 0.
  - Allocate, wakeup and issue in the same cycle are discarded.
- occupancy next = occupancy + alloc_fire - issue_fire. The same-cycle alloc and issue of different entries nets 0.
- JAL (ctrl[7:6]=10): rename marks both sources ready; the station does not special-case it.
- Reset asserted mid-operation clears state immediately (asynchronous). The first allocate is accepted on the first edge after deassertion.

Decomposition:
- Shared package branch_sched_pkg holds:
  - typedef rs_entry_t {valid, ctrl, predictedPC, targetAddress, nxtPC, rob_tag, src1/src2 {rdy, tag, val}}
  - localparams for the JAL/JALR/branch encodings of ctrl[7:6]
- One sub-module: age_matrix_select.
  - ENTRIES×ENTRIES age bits.
  - Inputs: alloc one-hot, clear one-hot, request vector.
  - Output: oldest-request one-hot grant.
  - Uses the same clk/reset.

Test Plan:
- Reset, then alloc ready op (src1=5, src2=5, ctrl=8'b00_000_10_0 BEQ) with issue_ready=1 -> issue_valid=1 one edge later, issue_src1=issue_src2=5, occupancy back to 0.
- Alloc A (src1 tag 3 pending), then B fully ready; cdb_valid tag 3 data 0x10 one cycle later -> B issues first; A issues the cycle after CDB with issue_src1=0x10.
- Fill 4 entries all waiting on tag 7 -> alloc_ready=0 and occupancy=4. A 5th alloc_valid is not accepted. CDB tag 7 -> entries issue oldest-first, one per cycle.
- Hold issue_ready=0 with 2 ready entries -> issue_* stable, occupancy=1. Release -> the second op appears the next cycle.
- Alloc with pending tag 2 in the same cycle as CDB tag 2 data 0xABCD -> the entry is ready, issues next cycle with src=0xABCD.
- flush in the same cycle as alloc and issue with 3 entries valid -> after the edge issue_valid=0, occupancy=0, alloc_ready=1, and the flushed ops never appear on issue_*.
